// File: rtl/png_filter_sub.sv
// PNG scanline filter stage: prepends the per-row filter-type byte, applies
// the Sub filter, and packs bytes MSB-first into dat/num/lst words.
// Optional feature macro: FILTER_SUB_EN (defined: Sub filter, type 0x01;
// undefined: filter None, type 0x00, bytes pass through).
module png_filter_sub #(
  parameter int unsigned BPP     = 1,
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned NUM_WD  = 2,
  parameter int unsigned LEN_WD  = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [LEN_WD-1:0]  row_len_i,
  input  logic [LEN_WD-1:0]  row_num_i,
  input  logic               val_i,
  input  logic [7:0]         dat_i,
  output logic               rdy_o,
  output logic               val_o,
  output logic [DATA_WD-1:0] dat_o,
  output logic [NUM_WD-1:0]  num_o,
  output logic               lst_o,
  output logic               done_o
);

  localparam int unsigned NumBytes = DATA_WD / 8;

`ifdef FILTER_SUB_EN
  localparam logic [7:0] TypeByte = 8'h01;
`else
  localparam logic [7:0] TypeByte = 8'h00;
`endif

  typedef enum logic [2:0] {StIdle, StType, StData, StFlush, StDone} state_e;

  state_e              state_q, state_d;
  logic [LEN_WD-1:0]   row_len_q, row_len_d;
  logic [LEN_WD-1:0]   rows_left_q, rows_left_d;
  logic [LEN_WD-1:0]   byte_cnt_q, byte_cnt_d;
  logic                empty_q, empty_d;
  logic [DATA_WD-9:0]  pack_q, pack_d;
  logic [NUM_WD-1:0]   pack_cnt_q, pack_cnt_d;
  logic                val_q, val_d;
  logic [DATA_WD-1:0]  dat_q, dat_d;
  logic [NUM_WD-1:0]   num_q, num_d;
  logic                lst_q, lst_d;
  logic                done_q, done_d;

  logic       accept;
  logic       row_last;
  logic       img_last;
  logic [7:0] filt;
  logic       push;
  logic [7:0] push_byte;
  logic       push_last;
  logic       flush;

  assign accept   = (state_q == StData) && val_i;
  assign row_last = ((byte_cnt_q + LEN_WD'(1)) == row_len_q);
  assign img_last = row_last && (rows_left_q == LEN_WD'(1));

`ifdef FILTER_SUB_EN
  // Raw bytes of the last BPP positions; cleared per row so 'a' is 0 at row start.
  logic [BPP*8-1:0] hist_q, hist_d;

  // History shift: newest byte enters at the bottom, oldest sits at the top.
  always_comb begin
    hist_d = hist_q;
    if (state_q == StType) begin
      hist_d = '0;
    end else if (accept) begin
      for (int i = BPP - 1; i > 0; i--) begin
        hist_d[i*8 +: 8] = hist_q[(i-1)*8 +: 8];
      end
      hist_d[7:0] = dat_i;
    end
  end

  // History register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist_q <= '0;
    else       hist_q <= hist_d;
  end

  assign filt = dat_i - hist_q[BPP*8-1 -: 8];
`else
  assign filt = dat_i;
`endif

  // Control FSM: sequences type byte, row data, final flush and done.
  always_comb begin
    state_d     = state_q;
    row_len_d   = row_len_q;
    rows_left_d = rows_left_q;
    byte_cnt_d  = byte_cnt_q;
    empty_d     = empty_q;
    push        = 1'b0;
    push_byte   = 8'h00;
    push_last   = 1'b0;
    flush       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if ((row_len_i != '0) && (row_num_i != '0)) begin
            row_len_d   = row_len_i;
            rows_left_d = row_num_i;
            empty_d     = 1'b0;
            state_d     = StType;
          end else begin
            empty_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StType: begin
        push       = 1'b1;
        push_byte  = TypeByte;
        byte_cnt_d = '0;
        state_d    = StData;
      end
      StData: begin
        if (accept) begin
          push       = 1'b1;
          push_byte  = filt;
          push_last  = img_last;
          byte_cnt_d = byte_cnt_q + LEN_WD'(1);
          if (row_last) begin
            rows_left_d = rows_left_q - LEN_WD'(1);
            state_d     = img_last ? StFlush : StType;
          end
        end
      end
      StFlush: begin
        flush   = 1'b1;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Packer: collect bytes MSB-first, emit full words or the final partial word.
  always_comb begin
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    val_d      = 1'b0;
    dat_d      = dat_q;
    num_d      = num_q;
    lst_d      = lst_q;
    // done follows the last word by one cycle; empty images have no last word
    done_d     = (val_q && lst_q) || ((state_q == StDone) && empty_q);
    if (push) begin
      if (pack_cnt_q == NUM_WD'(NumBytes - 1)) begin
        val_d      = 1'b1;
        dat_d      = {pack_q, push_byte};
        num_d      = NUM_WD'(NumBytes - 1);
        lst_d      = push_last;
        pack_d     = '0;
        pack_cnt_d = '0;
      end else begin
        for (int i = 0; i < NumBytes - 1; i++) begin
          if (pack_cnt_q == NUM_WD'(i)) pack_d[(NumBytes-2-i)*8 +: 8] = push_byte;
        end
        pack_cnt_d = pack_cnt_q + NUM_WD'(1);
      end
    end else if (flush && (pack_cnt_q != '0)) begin
      val_d      = 1'b1;
      dat_d      = {pack_q, 8'h00};
      num_d      = pack_cnt_q - NUM_WD'(1);
      lst_d      = 1'b1;
      pack_d     = '0;
      pack_cnt_d = '0;
    end
  end

  // State, counters, packer and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      row_len_q   <= '0;
      rows_left_q <= '0;
      byte_cnt_q  <= '0;
      empty_q     <= 1'b0;
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      val_q       <= 1'b0;
      dat_q       <= '0;
      num_q       <= '0;
      lst_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_len_q   <= row_len_d;
      rows_left_q <= rows_left_d;
      byte_cnt_q  <= byte_cnt_d;
      empty_q     <= empty_d;
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      val_q       <= val_d;
      dat_q       <= dat_d;
      num_q       <= num_d;
      lst_q       <= lst_d;
      done_q      <= done_d;
    end
  end

  assign rdy_o  = (state_q == StData);
  assign val_o  = val_q;
  assign dat_o  = dat_q;
  assign num_o  = num_q;
  assign lst_o  = lst_q;
  assign done_o = done_q;

endmodule
